// File: rtl/rob_mc_pkg.sv
// Shared helpers for the multi-commit reorder buffer.
// Ring arithmetic used by the top and the age comparators.
package rob_mc_pkg;

    function automatic int unsigned rel_age(
        input int unsigned idx,
        input int unsigned head,
        input int unsigned depth
    );
        return (idx - head) & (depth - 1);
    endfunction

endpackage

// File: rtl/rob_mc_age.sv
// Index-to-age conversion relative to head, plus the occupied compare.
// One instance per CDB port and one for the flush index.
module rob_mc_age
    import rob_mc_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W:0]   head,
    input  logic [IDX_W:0]   cnt,
    output logic [IDX_W-1:0] age,
    output logic             occupied
);

    assign age = IDX_W'(rel_age(32'(idx), 32'(head[IDX_W-1:0]), 2 ** IDX_W));
    assign occupied = {1'b0, age} < cnt;

endmodule

// File: rtl/rob_mc.sv
// Reorder buffer with N CDB ports, multi-slot in-order commit
// and selective flush of entries younger than a given index.
module rob_mc
    import rob_mc_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int NUM_CDB   = 2,
    parameter int COMMIT_W  = 2,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq_valid,
    input  logic [PAYLOAD_W-1:0]          enq_payload,
    output logic                          enq_ready,
    output logic [IDX_W-1:0]              enq_idx,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*IDX_W-1:0]      cdb_idx,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_data,
    output logic [COMMIT_W-1:0]           commit_valid,
    output logic [COMMIT_W*IDX_W-1:0]     commit_idx,
    output logic [COMMIT_W*PAYLOAD_W-1:0] commit_payload,
    output logic [COMMIT_W*DATA_W-1:0]    commit_data,
    input  logic [COMMIT_W-1:0]           commit_ack,
    input  logic                          flush_valid,
    input  logic [IDX_W-1:0]              flush_idx,
    input  logic                          flush_all,
    output logic                          flush_err,
    output logic [IDX_W:0]                count
);

    typedef logic [IDX_W:0] rob_ptr_t;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [DATA_W-1:0]    data;
    } rob_mc_entry_t;

    rob_mc_entry_t    ent_q [DEPTH];
    logic [DEPTH-1:0] done_q, done_nxt, hit;
    logic [DATA_W-1:0] wdata [DEPTH];
    rob_ptr_t head_q, tail_q, tail_nxt, cnt, k, keep_len, fl_end;
    logic flush_err_q, full, enq_fire, fl_hit, fl_occ;
    logic [IDX_W-1:0] fl_age;
    logic [IDX_W-1:0] cdb_age [NUM_CDB];
    logic [NUM_CDB-1:0] cdb_occ, cdb_ok;

    assign cnt       = tail_q - head_q;
    assign full      = cnt == rob_ptr_t'(DEPTH);
    assign enq_ready = ~full & ~flush_valid & ~flush_all;
    assign enq_fire  = enq_valid & enq_ready;
    assign enq_idx   = tail_q[IDX_W-1:0];
    assign count     = cnt;
    assign flush_err = flush_err_q;

    rob_mc_age #(.IDX_W(IDX_W)) u_fl_age (
        .idx(flush_idx), .head(head_q), .cnt(cnt),
        .age(fl_age), .occupied(fl_occ)
    );

    for (genvar p = 0; p < NUM_CDB; p++) begin : g_cdb
        rob_mc_age #(.IDX_W(IDX_W)) u_age (
            .idx(cdb_idx[p*IDX_W +: IDX_W]), .head(head_q), .cnt(cnt),
            .age(cdb_age[p]), .occupied(cdb_occ[p])
        );
        // Entries retiring or squashed this cycle must not be revived.
        assign cdb_ok[p] = cdb_valid[p] & cdb_occ[p]
                         & ({1'b0, cdb_age[p]} >= k)
                         & ({1'b0, cdb_age[p]} < keep_len);
    end

    always_comb begin
        k = '0;
        for (int i = 0; i < COMMIT_W; i++)
            if (commit_ack[i]) k = k + rob_ptr_t'(1);
    end

    // Surviving span measured from the current head; a flush that
    // lands inside the retiring group leaves nothing behind it.
    assign fl_end = {1'b0, fl_age} + rob_ptr_t'(1);

    always_comb begin
        fl_hit   = flush_valid & ~flush_all & fl_occ;
        keep_len = cnt;
        if (fl_hit) keep_len = (fl_end > k) ? fl_end : k;
        tail_nxt = tail_q;
        if (fl_hit)        tail_nxt = head_q + keep_len;
        else if (enq_fire) tail_nxt = tail_q + rob_ptr_t'(1);
    end

    always_comb begin
        int unsigned age_j;
        logic        alive;
        done_nxt = '0;
        hit      = '0;
        for (int j = 0; j < DEPTH; j++) begin
            wdata[j] = '0;
            for (int p = 0; p < NUM_CDB; p++) begin
                if (cdb_ok[p] && cdb_idx[p*IDX_W +: IDX_W] == IDX_W'(j)) begin
                    hit[j]   = 1'b1;
                    wdata[j] = cdb_data[p*DATA_W +: DATA_W];
                end
            end
            age_j = rel_age(j, 32'(head_q[IDX_W-1:0]), DEPTH);
            alive = age_j >= 32'(k) && age_j < 32'(keep_len);
            done_nxt[j] = ~flush_all & alive & (done_q[j] | hit[j]);
        end
    end

    always_comb begin
        logic             prev;
        logic             v;
        logic [IDX_W-1:0] sidx;
        commit_valid   = '0;
        commit_idx     = '0;
        commit_payload = '0;
        commit_data    = '0;
        prev = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            sidx = head_q[IDX_W-1:0] + IDX_W'(i);
            v    = (rob_ptr_t'(i) < cnt) & done_q[sidx] & prev;
            prev = v;
            commit_valid[i]                       = v;
            commit_idx[i*IDX_W +: IDX_W]          = sidx;
            commit_payload[i*PAYLOAD_W +: PAYLOAD_W] = ent_q[sidx].payload;
            commit_data[i*DATA_W +: DATA_W]       = ent_q[sidx].data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            done_q      <= '0;
            flush_err_q <= 1'b0;
        end else if (flush_all) begin
            head_q      <= '0;
            tail_q      <= '0;
            done_q      <= '0;
            flush_err_q <= 1'b0;
        end else begin
            head_q      <= head_q + k;
            tail_q      <= tail_nxt;
            done_q      <= done_nxt;
            flush_err_q <= flush_valid & ~fl_occ;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) ent_q[tail_q[IDX_W-1:0]].payload <= enq_payload;
        for (int j = 0; j < DEPTH; j++)
            if (hit[j] && !flush_all) ent_q[j].data <= wdata[j];
    end

endmodule
